// File: rtl/itcm_ahb_slv_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : itcm_ahb_slv_if                                           |
// | Brief   : AHB-Lite signal bundle between fetch master and ITCM slave|
// | Rev     : 1.0                                                       |
// +--------------------------------------------------------------------+
interface itcm_ahb_slv_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [6:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface
`default_nettype wire

// File: rtl/itcm_ahb_slv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : itcm_ahb_slv                                              |
// | Brief   : AHB-Lite slave for the instruction TCM with programmable  |
// |           wait states and two-cycle ERROR responses. Define         |
// |           ITCM_BOOT_CLEAR_EN to zero the memory after reset.        |
// | Rev     : 1.0                                                       |
// +--------------------------------------------------------------------+
module itcm_ahb_slv #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 1
) (
    input  wire logic     hclk,
    input  wire logic     hrstn,
    itcm_ahb_slv_if.slave bus,
    output logic          itcm_ready
);
    localparam int          c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] c_SPAN = 33'(DEPTH) << 2;
    localparam logic [2:0]  c_WS   = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_DATA  = 3'd2,
        S_ERR1  = 3'd3,
        S_ERR2  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

`ifdef ITCM_BOOT_CLEAR_EN
    localparam state_t c_RST_STATE = S_CLEAR;
`else
    localparam state_t c_RST_STATE = S_IDLE;
`endif

    state_t          r_state;
    state_t          w_next;
    state_t          w_accept_state;
    logic [2:0]      r_cnt;
    logic [c_AW-1:0] r_word;
    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_write;
    logic [31:0]     r_mem [DEPTH];

    logic [32:0]     w_off;
    logic            w_in_range;
    logic            w_bad;
    logic            w_accept;
    logic            w_clr_last;
    logic [3:0]      w_be;
    logic            w_unused;

    assign w_off      = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
    assign w_in_range = (bus.haddr >= BASE_ADDR) && (w_off < c_SPAN);
    assign w_bad      = !w_in_range
                     || (bus.hsize > 3'd2)
                     || ((bus.hsize == 3'd1) && bus.haddr[0])
                     || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
    // A new address phase can only land while this slave is presenting ready.
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2))
                     && bus.hsel && bus.hready && bus.htrans[1];
    assign w_accept_state = w_bad ? S_ERR1 : ((WAIT_STATES == 0) ? S_DATA : S_WAIT);

    assign w_unused = ^{bus.hburst, bus.hprot, bus.hmastlock, w_off, w_clr_last};

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lane;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_state <= c_RST_STATE;
            r_cnt   <= 3'd0;
            r_word  <= '0;
            r_lane  <= 2'b00;
            r_size  <= 2'b00;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= c_WS;
                r_word  <= w_off[c_AW+1:2];
                r_lane  <= bus.haddr[1:0];
                r_size  <= bus.hsize[1:0];
                r_write <= bus.hwrite;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

`ifdef ITCM_BOOT_CLEAR_EN
    logic [c_AW-1:0] r_clr;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_clr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr <= r_clr + c_AW'(1);
        end
    end

    assign w_clr_last = (r_clr == c_AW'(DEPTH - 1));
    assign itcm_ready = (r_state != S_CLEAR);
`else
    logic r_ready;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign w_clr_last = 1'b1;
    assign itcm_ready = r_ready;
`endif

    // Storage has no reset so contents survive hrstn; gating on hrstn drops in-flight writes.
    always_ff @(posedge hclk) begin
`ifdef ITCM_BOOT_CLEAR_EN
        if (hrstn && (r_state == S_CLEAR)) begin
            r_mem[r_clr] <= 32'h0;
        end
`endif
        if (hrstn && (r_state == S_DATA) && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_word][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.hreadyout = 1'b1;
        bus.hresp     = 1'b0;
        bus.hrdata    = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_accept_state;
                end
            end
            S_WAIT: begin
                bus.hreadyout = 1'b0;
                if (r_cnt <= 3'd1) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (!r_write) begin
                    bus.hrdata = r_mem[r_word];
                end
                w_next = w_accept ? w_accept_state : S_IDLE;
            end
            S_ERR1: begin
                bus.hreadyout = 1'b0;
                bus.hresp     = 1'b1;
                w_next        = S_ERR2;
            end
            S_ERR2: begin
                bus.hresp = 1'b1;
                w_next    = w_accept ? w_accept_state : S_IDLE;
            end
            S_CLEAR: begin
                bus.hreadyout = 1'b0;
                if (w_clr_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule
`default_nettype wire
